// File: rtl/gen_trckr_pkg.sv
// Shared definitions for the stream source and the tracker sink:
// FSM state encodings and default widths.
package gen_trckr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } trk_state_t;

    localparam int DEF_DW    = 16;
    localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/tracker_ready_gen.sv
// Backpressure pattern generator: a wrapping phase counter and the
// registered up_ready output, low one cycle in every STALL_PERIOD.
module tracker_ready_gen #(
    parameter int STALL_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,        // IDLE -> SYNC on this edge
    input  logic active,       // current state is SYNC or TRACK
    input  logic next_active,  // next state is SYNC or TRACK
    output logic up_ready
);

    localparam int  RW     = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam int  LAST   = (STALL_PERIOD > 1) ? STALL_PERIOD - 1 : 0;
    localparam bit  STALLS = (STALL_PERIOD > 1);

    logic [RW-1:0] rdy_cnt;
    logic [RW-1:0] rdy_cnt_next;
    logic          ready_next;

    // Next phase: cleared at run start, advances and wraps while running.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rdy_cnt_next = rdy_cnt;
        if (start) begin
            rdy_cnt_next = '0;
        end else if (active) begin
            rdy_cnt_next = (rdy_cnt == RW'(LAST)) ? '0 : rdy_cnt + RW'(1);
        end
        ready_next = next_active && !(STALLS && (rdy_cnt_next == RW'(LAST)));
    end

    // Phase counter and ready register; up_ready never sees up_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_cnt  <= '0;
            up_ready <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            rdy_cnt  <= rdy_cnt_next;
            up_ready <= ready_next;
        end
    end

endmodule

// File: rtl/tracker_logic.sv
// Stream sink/checker: applies a backpressure pattern, checks that each
// accepted word is the previous one + 1, keeps saturating statistics,
// first-error capture and a stall watchdog.
module tracker_logic
    import gen_trckr_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int STALL_PERIOD = 4,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             up_valid,
    input  logic [DW-1:0]    up_data,
    output logic             up_ready,
    output logic [CNT_W-1:0] rcv_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [DW-1:0]    first_err_exp,
    output logic [DW-1:0]    first_err_got,
    output logic             timeout
);

    // Idle counter saturates at TIMEOUT, so it only needs to hold that value.
    localparam int IW = $clog2(TIMEOUT + 2);

    trk_state_t    state;
    trk_state_t    next_state;
    logic [DW-1:0] exp;
    logic [IW-1:0] idle_cnt;
    logic          beat;
    logic          start;
    logic          active;

    assign active = (state != IDLE);
    assign beat   = active && up_valid && up_ready;
    assign start  = (state == IDLE) && chk_en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a beat on the edge chk_en falls is still processed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (chk_en) next_state = SYNC;
            SYNC:    if (!chk_en) next_state = IDLE;
                     else if (beat) next_state = TRACK;
            TRACK:   if (!chk_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    tracker_ready_gen #(
        .STALL_PERIOD(STALL_PERIOD)
    ) u_ready_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .active     (active),
        .next_active(next_state != IDLE),
        .up_ready   (up_ready)
    );

    // Sequence check, statistics and watchdog; all frozen while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp           <= '0;
            idle_cnt      <= '0;
            rcv_count     <= '0;
            err_count     <= '0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            timeout       <= 1'b0;
        end else if (start) begin
            exp           <= '0;
            idle_cnt      <= '0;
            rcv_count     <= '0;
            err_count     <= '0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            timeout       <= 1'b0;
        end else if (active) begin
            if (beat) begin
                idle_cnt <= '0;
                exp      <= up_data + DW'(1);
                if (state == SYNC) begin
                    rcv_count <= CNT_W'(1);
                end else begin
                    if (!(&rcv_count)) rcv_count <= rcv_count + CNT_W'(1);
                    if (up_data != exp) begin
                        if (!(&err_count)) err_count <= err_count + CNT_W'(1);
                        if (!err_flag) begin
                            first_err_exp <= exp;
                            first_err_got <= up_data;
                            err_flag      <= 1'b1;
                        end
                    end
                end
            end else begin
                if (idle_cnt != IW'(TIMEOUT)) idle_cnt <= idle_cnt + IW'(1);
                if ((TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT - 1))) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tracker_logic.sv
// Self-checking bench for tracker_logic: drives words, keeps an independent
// reference model, and compares the statistics after every accepted beat.
module tb_tracker_logic;

    localparam int DW    = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             chk_en;
    logic             up_valid;
    logic [DW-1:0]    up_data;
    logic             up_ready;
    logic [CNT_W-1:0] rcv_count;
    logic [CNT_W-1:0] err_count;
    logic             err_flag;
    logic [DW-1:0]    first_err_exp;
    logic [DW-1:0]    first_err_got;
    logic             timeout;

    typedef struct {
        logic [CNT_W-1:0] rcv;
        logic [CNT_W-1:0] err;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    logic          beat_seen = 1'b0;

    // Reference model state.
    logic          m_synced;
    logic [DW-1:0] m_exp;
    int            m_rcv;
    int            m_err;

    tracker_logic #(
        .DW(DW), .STALL_PERIOD(4), .TIMEOUT(64), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .chk_en       (chk_en),
        .up_valid     (up_valid),
        .up_data      (up_data),
        .up_ready     (up_ready),
        .rcv_count    (rcv_count),
        .err_count    (err_count),
        .err_flag     (err_flag),
        .first_err_exp(first_err_exp),
        .first_err_got(first_err_got),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Record accepted beats, then compare against the scoreboard at negedge.
    always @(posedge clk) beat_seen <= up_valid && up_ready;

    always @(negedge clk) begin
        if (beat_seen) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("beat_rcv", rcv_count, e.rcv);
                check("beat_err", err_count, e.err);
            end
        end
    end

    task automatic model_start();
        m_synced = 1'b0;
        m_exp    = '0;
        m_rcv    = 0;
        m_err    = 0;
    endtask

    // Present one word until accepted; push the expected stats first.
    task automatic send(input logic [DW-1:0] d);
        exp_t e;
        logic r;
        bit   done = 0;
        if (!m_synced) begin
            m_synced = 1'b1;
            m_rcv    = 1;
        end else begin
            m_rcv++;
            if (d != m_exp) m_err++;
        end
        m_exp = d + 16'd1;
        e.rcv = m_rcv;
        e.err = m_err;
        sb_q.push_back(e);
        up_valid = 1'b1;
        up_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            r = up_ready;
            @(posedge clk);
            if (r) done = 1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        #1;
        up_valid = 1'b0;
    endtask

    // Drop chk_en, confirm stats are held, then start a fresh run.
    task automatic start_run();
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_rcv", rcv_count, m_rcv);
        check("idle_ready", up_ready, 1'b0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        model_start();
        check("start_rcv_clr", rcv_count, 32'd0);
        check("start_flag_clr", {err_flag, timeout}, 2'b00);
        check("ready_latency", up_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rcv"}, rcv_count, 32'd0);
        check({tag, "_err"}, err_count, 32'd0);
        check({tag, "_misc"}, {up_ready, err_flag, timeout}, 3'b000);
        check({tag, "_cap"}, {first_err_exp, first_err_got}, 32'd0);
    endtask

    initial begin
        logic rdy_log[12];
        rst_n    = 1'b0;
        chk_en   = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        model_start();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 rst_n = 1'b1;

        // 1: clean stream 1..10
        start_run();
        for (int i = 1; i <= 10; i++) send(i[DW-1:0]);
        #2;
        check("t1_rcv", rcv_count, 32'd10);
        check("t1_err", err_count, 32'd0);
        check("t1_flags", {err_flag, timeout}, 2'b00);

        // 2: single gap 5,6,8,9
        start_run();
        send(16'd5); send(16'd6); send(16'd8); send(16'd9);
        #2;
        check("t2_err", err_count, 32'd1);
        check("t2_flag", err_flag, 1'b1);
        check("t2_exp", first_err_exp, 16'd7);
        check("t2_got", first_err_got, 16'd8);

        // 3: wrap through zero
        start_run();
        send(16'hFFFE); send(16'hFFFF); send(16'h0000); send(16'h0001);
        #2;
        check("t3_err", err_count, 32'd0);
        check("t3_rcv", rcv_count, 32'd4);

        // 4: ready pattern, then 8 back-to-back beats across stalls
        start_run();
        for (int i = 0; i < 12; i++) begin
            rdy_log[i] = up_ready;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 12; i++) check($sformatf("t4_rdy%0d", i), rdy_log[i], (i % 4) != 3);
        for (int i = 0; i < 8; i++) send(16'h0100 + i[DW-1:0]);
        #2;
        check("t4_rcv", rcv_count, 32'd8);
        check("t4_err", err_count, 32'd0);

        // 5: watchdog boundary
        repeat (63) @(posedge clk);
        #1;
        check("t5_no_to_63", timeout, 1'b0);
        @(posedge clk);
        #1;
        check("t5_to_64", timeout, 1'b1);
        send(16'h0108);
        #2;
        check("t5_sticky", timeout, 1'b1);

        // 6: async reset mid-cycle, then restart
        start_run();
        send(16'h0040); send(16'h0041);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        #3 rst_n = 1'b1;
        model_start();
        @(posedge clk);
        #1;
        check("t6_ready", up_ready, 1'b1);
        send(16'h0064); send(16'h0065);
        #2;
        check("t6_rcv", rcv_count, 32'd2);
        check("t6_err", {err_flag, err_count[0]}, 2'b00);

        repeat (2) @(posedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
